fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS core; replaces the single-cycle PC unit.
- Owns the PC, drives the word address into the instruction memory (combinational read), and captures instruction and PC+4 into the IF/ID register for decode.
- Accepts stall from the hazard unit, jump redirect from decode and branch redirect from execute.

---
 rtl/mips_pkg.sv | 13 +
 rtl/if_id_reg.sv | 32 +++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage state encoding and instruction constants
package mips_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_WARM = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold and bubble-flush controls
module if_id_reg
   import mips_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               hold,
   input  logic               flush,
   input  logic [INSTR_W-1:0] instr_d,
   input  logic [31:0]        pc4_d,
   output logic [INSTR_W-1:0] instr_q,
   output logic [31:0]        pc4_q,
   output logic               valid_q
);

   // Flush wins over hold; a bubble keeps the old PC+4 since nothing reads it while invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= NOP_INSTR;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else if (flush) begin
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else if (!hold) begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS fetch stage: PC, next-PC mux, WARM/RUN/HALT FSM; FETCH_PERF_CNT_EN adds stall/flush counters
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          IM_ADDR_W = 5
)(
   input  logic                 Clk,
   input  logic                 Reset,
   output logic [IM_ADDR_W-1:0] ImAdr,
   input  logic [INSTR_W-1:0]   ImData,
   input  logic                 Stall,
   input  logic                 JumpReq,
   input  logic [25:0]          JumpIndex,
   input  logic                 BranchReq,
   input  logic [31:0]          BranchTarget,
   input  logic                 HaltReq,
   output logic [INSTR_W-1:0]   IfIdInstr,
   output logic [31:0]          IfIdPc4,
   output logic                 IfIdValid,
   output logic [31:0]          Pc,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]          StallCnt,
   output logic [31:0]          FlushCnt,
`endif
   output logic                 Halted
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pc_plus4;
   logic [31:0]  jump_target;
   logic         hold, flush;
   logic         stall_hit, flush_hit;

   assign pc_plus4    = pc_q + 32'd4;
   assign jump_target = {IfIdPc4[31:28], JumpIndex, 2'b00};

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      hold      = 1'b0;
      flush     = 1'b0;
      stall_hit = 1'b0;
      flush_hit = 1'b0;
      case (state_q)
         FETCH_WARM: begin
            flush   = 1'b1;
            state_d = FETCH_RUN;
         end
         FETCH_RUN: begin
            if (BranchReq) begin
               pc_d      = BranchTarget;
               flush     = 1'b1;
               flush_hit = 1'b1;
            end else if (JumpReq) begin
               pc_d      = jump_target;
               flush     = 1'b1;
               flush_hit = 1'b1;
            end else if (Stall) begin
               hold      = 1'b1;
               stall_hit = 1'b1;
            end else begin
               pc_d = pc_plus4;
            end
            if (HaltReq) state_d = FETCH_HALT;
         end
         FETCH_HALT: begin
            // Redirects from older in-flight instructions still land while halted.
            flush = 1'b1;
            if (BranchReq) begin
               pc_d      = BranchTarget;
               flush_hit = 1'b1;
            end else if (JumpReq) begin
               pc_d      = jump_target;
               flush_hit = 1'b1;
            end
            if (!HaltReq) state_d = FETCH_RUN;
         end
         default: state_d = FETCH_WARM;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= FETCH_WARM;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   if_id_reg u_if_id_reg (
      .clk     (Clk),
      .rst     (Reset),
      .hold    (hold),
      .flush   (flush),
      .instr_d (ImData),
      .pc4_d   (pc_plus4),
      .instr_q (IfIdInstr),
      .pc4_q   (IfIdPc4),
      .valid_q (IfIdValid)
   );

   assign Pc     = pc_q;
   assign ImAdr  = pc_q[IM_ADDR_W+1:2];
   assign Halted = (state_q == FETCH_HALT);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stall_cnt_q <= 32'h0;
         flush_cnt_q <= 32'h0;
      end else begin
         if (stall_hit && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (flush_hit && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
`else
   logic unused_hits;
   assign unused_hits = stall_hit ^ flush_hit;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a behavioural fetch model
module tb_fetch_stage;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [4:0]  ImAdr;
   logic [31:0] ImData;
   logic        Stall = 1'b0;
   logic        JumpReq = 1'b0;
   logic [25:0] JumpIndex = '0;
   logic        BranchReq = 1'b0;
   logic [31:0] BranchTarget = '0;
   logic        HaltReq = 1'b0;
   logic [31:0] IfIdInstr;
   logic [31:0] IfIdPc4;
   logic        IfIdValid;
   logic [31:0] Pc;
   logic        Halted;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] StallCnt;
   logic [31:0] FlushCnt;
`endif

   logic [31:0] imem [32];
   assign ImData = imem[ImAdr];

   fetch_stage dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .ImAdr        (ImAdr),
      .ImData       (ImData),
      .Stall        (Stall),
      .JumpReq      (JumpReq),
      .JumpIndex    (JumpIndex),
      .BranchReq    (BranchReq),
      .BranchTarget (BranchTarget),
      .HaltReq      (HaltReq),
      .IfIdInstr    (IfIdInstr),
      .IfIdPc4      (IfIdPc4),
      .IfIdValid    (IfIdValid),
      .Pc           (Pc),
`ifdef FETCH_PERF_CNT_EN
      .StallCnt     (StallCnt),
      .FlushCnt     (FlushCnt),
`endif
      .Halted       (Halted)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Reference model: mode 0 = just out of reset, 1 = fetching, 2 = halted.
   int          m_mode;
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;
   int unsigned m_stalls, m_flushes;

   task automatic model_reset();
      m_mode = 0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_stalls = 0; m_flushes = 0;
   endtask

   task automatic check_all(input string ctx);
      check({ctx, ".Pc"}, Pc, m_pc);
      check({ctx, ".ImAdr"}, {27'h0, ImAdr}, {27'h0, m_pc[6:2]});
      check({ctx, ".Valid"}, {31'h0, IfIdValid}, {31'h0, m_valid});
      check({ctx, ".Instr"}, IfIdInstr, m_instr);
      if (m_valid) check({ctx, ".Pc4"}, IfIdPc4, m_pc4);
      check({ctx, ".Halted"}, {31'h0, Halted}, {31'h0, m_mode == 2});
`ifdef FETCH_PERF_CNT_EN
      check({ctx, ".StallCnt"}, StallCnt, m_stalls);
      check({ctx, ".FlushCnt"}, FlushCnt, m_flushes);
`endif
   endtask

   task automatic step(input string ctx);
      logic [31:0] n_pc, n_instr, n_pc4, redirect;
      logic        n_valid, redir;
      int          n_mode;
      n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid; n_mode = m_mode;
      redir = BranchReq || JumpReq;
      redirect = BranchReq ? BranchTarget : {m_pc4[31:28], JumpIndex, 2'b00};
      if (m_mode == 0) begin
         n_instr = 0; n_valid = 0; n_mode = 1;
      end else if (m_mode == 1) begin
         if (redir) begin
            n_pc = redirect; n_instr = 0; n_valid = 0; m_flushes++;
         end else if (Stall) begin
            m_stalls++;
         end else begin
            n_instr = imem[m_pc[6:2]]; n_pc = m_pc + 4; n_pc4 = m_pc + 4; n_valid = 1;
         end
         if (HaltReq) n_mode = 2;
      end else begin
         if (redir) begin
            n_pc = redirect; m_flushes++;
         end
         n_instr = 0; n_valid = 0;
         if (!HaltReq) n_mode = 1;
      end
      @(posedge Clk);
      #1;
      m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid; m_mode = n_mode;
      check_all(ctx);
   endtask

   task automatic idle();
      Stall = 0; JumpReq = 0; BranchReq = 0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) imem[i] = $urandom;
      model_reset();
      #2;
      check_all("reset");
      @(negedge Clk);
      Reset = 0;
      step("warm");
      check("warm.Pc0", Pc, 32'h0);
      step("run0");
      step("run1");
      check("run1.Pc8", Pc, 32'h8);
      check("run1.Pc4", IfIdPc4, 32'h8);

      @(negedge Clk); JumpReq = 1; JumpIndex = 26'h10;
      step("jump");
      check("jump.Pc40", Pc, 32'h40);
      @(negedge Clk); idle();
      step("after_jump");
      check("after_jump.instr", IfIdInstr, imem[16]);

      @(negedge Clk); BranchReq = 1; JumpReq = 1; Stall = 1; BranchTarget = 32'h24;
      step("bjs");
      check("bjs.Pc24", Pc, 32'h24);

      @(negedge Clk); idle(); BranchReq = 1; BranchTarget = 32'h10;
      step("br10");
      @(negedge Clk); idle();
      step("fill");
      @(negedge Clk); BranchReq = 1; BranchTarget = 32'h10;
      step("br10b");
      @(negedge Clk); idle();
      step("pre_stall");
      @(negedge Clk); BranchReq = 1; BranchTarget = 32'h0C;
      step("br0c");
      @(negedge Clk); idle();
      step("to10");
      check("to10.Pc", Pc, 32'h10);
      @(negedge Clk); Stall = 1;
      for (int i = 0; i < 3; i++) step("stall");
      @(negedge Clk); idle();
      step("resume");
      check("resume.Pc14", Pc, 32'h14);

      @(negedge Clk); HaltReq = 1;
      for (int i = 0; i < 4; i++) step("halt");
      @(negedge Clk); HaltReq = 0;
      step("unhalt");
      step("refetch");

      @(negedge Clk); BranchReq = 1; BranchTarget = 32'hFFFF_FFFC;
      step("br_top");
      @(negedge Clk); idle();
      step("wrap");
      check("wrap.Pc0", Pc, 32'h0);
      for (int i = 0; i < 20 && m_pc != 32'h30; i++) step("to30");
      check("at30", Pc, 32'h30);

      @(posedge Clk); #3;
      Reset = 1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge Clk); Reset = 0;
      step("warm2");
      step("run2");

      for (int i = 0; i < 400; i++) begin
         @(negedge Clk);
         BranchReq    = ($urandom_range(0, 9) == 0);
         JumpReq      = ($urandom_range(0, 9) == 0);
         Stall        = ($urandom_range(0, 4) == 0);
         BranchTarget = {$urandom_range(0, 255), 2'b00};
         JumpIndex    = 26'($urandom_range(0, 255));
         if ($urandom_range(0, 19) == 0) HaltReq = ~HaltReq;
         step("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
